// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: command codes, payload
// lengths, FSM state encoding and the payload alignment helper.
package uart_cmd_decoder_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_DATA   = 8'h01;
  localparam logic [7:0] CMD_CTRL   = 8'h02;
  localparam logic [7:0] CMD_FREQ   = 8'h03;
  localparam logic [7:0] CMD_PERIOD = 8'h04;
  localparam logic [7:0] CMD_REPEAT = 8'h05;

  // Payload byte counts (bytes after the command and optional channel byte)
  localparam logic [2:0] LEN_DATA   = 3'd4;
  localparam logic [2:0] LEN_CTRL   = 3'd1;
  localparam logic [2:0] LEN_FREQ   = 3'd4;
  localparam logic [2:0] LEN_PERIOD = 3'd2;
  localparam logic [2:0] LEN_REPEAT = 3'd1;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHANNEL = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  // Number of payload bytes for a 3-bit command code
  function automatic logic [2:0] payload_len(input logic [2:0] cmd);
    case (cmd)
      CMD_DATA[2:0]:   payload_len = LEN_DATA;
      CMD_CTRL[2:0]:   payload_len = LEN_CTRL;
      CMD_FREQ[2:0]:   payload_len = LEN_FREQ;
      CMD_PERIOD[2:0]: payload_len = LEN_PERIOD;
      CMD_REPEAT[2:0]: payload_len = LEN_REPEAT;
      default:         payload_len = 3'd1;
    endcase
  endfunction

  // Turn the final shift-register image (newest byte at [31:24]) into the
  // right-aligned, zero-filled write payload.
  function automatic logic [31:0] align_payload(input logic [2:0] cmd,
                                                input logic [31:0] sh);
    case (cmd)
      CMD_DATA[2:0], CMD_FREQ[2:0]:   align_payload = sh;
      CMD_CTRL[2:0], CMD_REPEAT[2:0]: align_payload = {24'h0, sh[31:24]};
      // PERIOD carries slow first, fast last; slow lands in the upper byte
      CMD_PERIOD[2:0]:                align_payload = {16'h0, sh[23:16], sh[31:24]};
      default:                        align_payload = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_idle_timeout_counter.sv
// Idle-gap watchdog for a frame in progress. Counts clocks while enabled,
// restarts on every clear, and flags expire on the TIMEOUT_CYCLES-th idle
// clock. A clear in the same cycle suppresses expire, so a late byte wins.
module idle_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = enable_i && !clear_i &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle-clock counter, held at zero while disabled or cleared
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || !enable_i) begin
      cnt_q <= '0;
    end else if (!expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: turns DATA/CTRL/FREQ/PERIOD/REPEAT frames
// from the UART receiver into single-cycle configuration-bus writes.
// Optional inter-byte timeout is built when CMD_TIMEOUT_EN is defined.
//
// Output handshake: wr_valid_o is a one-cycle strobe with no ready; the
// wr_type_o/wr_channel_o/wr_data_o fields are valid while it is high and
// hold until the next write. err_o is a one-cycle strobe for each dropped
// frame or stray byte, never coincident with wr_valid_o.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned OUTPUT_NUM     = 16,
  parameter int unsigned CH_W           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_done_tick_i,
  output logic            wr_valid_o,
  output logic [2:0]      wr_type_o,
  output logic [CH_W-1:0] wr_channel_o,
  output logic [31:0]     wr_data_o,
  output logic            busy_o,
  output logic            err_o,
  output state_t          dbg_state_o
);

  state_t          state_q;
  logic [2:0]      cmd_q;
  logic [7:0]      ch_q;
  logic            ch_bad_q;
  logic [2:0]      cnt_q;
  logic [31:0]     sh_q;
  logic [31:0]     sh_next;
  logic            timeout_expire;

  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;
  assign sh_next     = {rx_data_i, sh_q[31:8]};

`ifdef CMD_TIMEOUT_EN
  idle_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .clear_i  (rx_done_tick_i),
    .enable_i (state_q != ST_IDLE),
    .expire_o (timeout_expire)
  );
`else
  // No watchdog: a partial frame waits indefinitely. The parameter stays
  // referenced so both builds share one parameter list.
  assign timeout_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Frame parser FSM with registered write/error strobes
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 3'd0;
      ch_q         <= 8'd0;
      ch_bad_q     <= 1'b0;
      cnt_q        <= 3'd0;
      sh_q         <= 32'd0;
      wr_valid_o   <= 1'b0;
      wr_type_o    <= 3'd0;
      wr_channel_o <= '0;
      wr_data_o    <= 32'd0;
      err_o        <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      err_o      <= 1'b0;
      if (rx_done_tick_i) begin
        case (state_q)
          ST_IDLE: begin
            ch_q     <= 8'd0;
            ch_bad_q <= 1'b0;
            cnt_q    <= 3'd0;
            sh_q     <= 32'd0;
            cmd_q    <= rx_data_i[2:0];
            case (rx_data_i)
              CMD_DATA, CMD_CTRL, CMD_REPEAT: state_q <= ST_CHANNEL;
              CMD_FREQ, CMD_PERIOD:           state_q <= ST_PAYLOAD;
              default:                        err_o   <= 1'b1;
            endcase
          end
          ST_CHANNEL: begin
            ch_q     <= rx_data_i;
            ch_bad_q <= ({24'd0, rx_data_i} >= OUTPUT_NUM);
            state_q  <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            sh_q <= sh_next;
            if (cnt_q == payload_len(cmd_q) - 3'd1) begin
              state_q <= ST_IDLE;
              cnt_q   <= 3'd0;
              if (ch_bad_q) begin
                err_o <= 1'b1;
              end else begin
                wr_valid_o   <= 1'b1;
                wr_type_o    <= cmd_q;
                wr_channel_o <= CH_W'(ch_q);
                wr_data_o    <= align_payload(cmd_q, sh_next);
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (timeout_expire) begin
        state_q <= ST_IDLE;
        cnt_q   <= 3'd0;
        err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a queue-based scoreboard.
// Build with CMD_TIMEOUT_EN defined to exercise the inter-byte timeout.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int unsigned OUTPUT_NUM     = 16;
  localparam int unsigned CH_W           = 8;
  localparam int unsigned TIMEOUT_CYCLES = 100;
  localparam int          EXP_W          = 44;

  logic            clk;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_done_tick;
  logic            wr_valid;
  logic [2:0]      wr_type;
  logic [CH_W-1:0] wr_channel;
  logic [31:0]     wr_data;
  logic            busy;
  logic            err;
  state_t          dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int total;
  int bad;

  uart_cmd_decoder #(
    .OUTPUT_NUM     (OUTPUT_NUM),
    .CH_W           (CH_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_i          (clk),
    .rst_n          (rst_n),
    .rx_data_i      (rx_data),
    .rx_done_tick_i (rx_done_tick),
    .wr_valid_o     (wr_valid),
    .wr_type_o      (wr_type),
    .wr_channel_o   (wr_channel),
    .wr_data_o      (wr_data),
    .busy_o         (busy),
    .err_o          (err),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [EXP_W-1:0] exp_wr(input logic [2:0] t,
                                              input logic [7:0] ch,
                                              input logic [31:0] d);
    return {1'b0, t, ch, d};
  endfunction

  function automatic logic [EXP_W-1:0] exp_err();
    return {1'b1, 43'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_valid"}, 64'(wr_valid), 64'd0);
    check({tag, " wr_type"}, 64'(wr_type), 64'd0);
    check({tag, " wr_channel"}, 64'(wr_channel), 64'd0);
    check({tag, " wr_data"}, 64'(wr_data), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " err"}, 64'(err), 64'd0);
    check({tag, " state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; presents the byte for exactly one rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
  endtask

  // Frame bytes written in natural order, first byte most significant.
  task automatic send_frame(input string name, input logic [47:0] bytes,
                            input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[8*(n-1-i) +: 8]);
      if (i < n - 1) begin
        check({name, " busy mid-frame"}, 64'(busy), 64'd1);
      end else begin
        check({name, " strobe 1clk after last byte"}, 64'(wr_valid | err), 64'd1);
        check({name, " busy after commit"}, 64'(busy), 64'd0);
      end
    end
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    forever begin
      @(negedge clk);
      if (wr_valid && err) begin
        total++;
        bad++;
        $display("FAIL strobe_overlap: wr_valid=1 err=1 together");
      end
      if (wr_valid || err) begin
        a = err ? exp_err() : {1'b0, wr_type, wr_channel, wr_data};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got 0x%0h expected nothing", a);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", 64'(a), 64'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b1;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // DATA frame
    exp_q.push_back(exp_wr(3'd1, 8'd13, 32'h5555_5555));
    send_frame("data", 48'h01_0D_55_55_55_55, 6, 2);

    // FREQ frame, channel forced to 0
    exp_q.push_back(exp_wr(3'd3, 8'd0, 32'h1234_5678));
    send_frame("freq", 48'h03_78_56_34_12, 5, 2);

    // PERIOD then REPEAT back-to-back: REPEAT's command byte lands while
    // PERIOD's wr_valid is high
    exp_q.push_back(exp_wr(3'd4, 8'd0, 32'h0000_1405));
    exp_q.push_back(exp_wr(3'd5, 8'd14, 32'h0000_0002));
    send_frame("period", 48'h04_14_05, 3, 0);
    send_frame("repeat", 48'h05_0E_02, 3, 2);

    // Unknown byte, out-of-range CTRL channel, then a legal CTRL
    exp_q.push_back(exp_err());
    send_frame("unknown", 48'h7F, 1, 1);
    exp_q.push_back(exp_err());
    send_frame("ctrl_badch", 48'h02_10_03, 3, 1);
    exp_q.push_back(exp_wr(3'd2, 8'd15, 32'h0000_0005));
    send_frame("ctrl", 48'h02_0F_05, 3, 5);

    // Fields hold after the strobe
    check("hold wr_type", 64'(wr_type), 64'd2);
    check("hold wr_channel", 64'(wr_channel), 64'd15);
    check("hold wr_data", 64'(wr_data), 64'h5);
    check("hold wr_valid low", 64'(wr_valid), 64'd0);

`ifdef CMD_TIMEOUT_EN
    // Stall inside a DATA frame: abort after TIMEOUT_CYCLES idle clocks
    exp_q.push_back(exp_err());
    send_byte(8'h01);
    @(negedge clk);
    send_byte(8'h02);
    k = 0;
    while (k < 130 && !err) begin
      @(negedge clk);
      k++;
    end
    check("timeout err delay", 64'(k), 64'(TIMEOUT_CYCLES));
    check("timeout back to idle", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    exp_q.push_back(exp_wr(3'd1, 8'd3, 32'hDDCC_BBAA));
    send_frame("after_timeout", 48'h01_03_AA_BB_CC_DD, 6, 2);
`else
    // Without the watchdog a stalled frame simply waits, then completes
    send_byte(8'h01);
    @(negedge clk);
    send_byte(8'h02);
    repeat (150) @(negedge clk);
    check("stall still busy", 64'(busy), 64'd1);
    check("stall state payload", 64'(dbg_state), 64'(ST_PAYLOAD));
    exp_q.push_back(exp_wr(3'd1, 8'd2, 32'h4433_2211));
    send_frame("stall_finish", 48'h11_22_33_44, 4, 2);
`endif

    // Reset in the middle of a DATA frame
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hAA);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.push_back(exp_wr(3'd1, 8'd5, 32'h4433_2211));
    send_frame("after_reset", 48'h01_05_11_22_33_44, 6, 2);

    // Drain with a bound
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
